// File: rtl/axi_rd_arbiter_pkg.sv
// axi_rd_arbiter_pkg: shared state encoding and line geometry for the AXI read arbiter
package axi_rd_arbiter_pkg;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ADDR = 2'd1, S_DATA = 2'd2} state_t;
  localparam int LINE_BYTES = 64;
  localparam int BEATS_DEF = 16;
endpackage

// File: rtl/axi_rd_arbiter_rr_pick.sv
// rr_pick: combinational round-robin priority encoder, searching from ptr+1 modulo N
module rr_pick #(
  parameter int N = 2,
  parameter int IDW = 3
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [IDW-1:0] gnt_idx,
  output logic           any
);
  logic [IDW:0] sh;
  logic [N-1:0] rot;
  assign sh = {1'b0, ptr} + 1'b1;
  assign rot = N'({req, req} >> sh);
  assign any = |req;
  always_comb begin
    gnt_idx = '0;
    for (int j = N - 1; j >= 0; j--)
      if (rot[j]) gnt_idx = IDW'((j + int'(sh)) % N);
  end
endmodule

// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: round-robin sharing of one AXI read channel among N line-fill requesters
module axi_rd_arbiter
  import axi_rd_arbiter_pkg::*;
#(
  parameter int N = 2,
  parameter int BEATS = BEATS_DEF,
  parameter int IDW = 3
) (
  input  logic             AXI_clk,
  input  logic             AXI_rst_n,
  input  logic [N-1:0]     req_valid,
  input  logic [32*N-1:0]  req_addr,
  output logic [N-1:0]     req_ready,
  output logic [31:0]      AXI_araddr,
  output logic [3:0]       AXI_arlen,
  output logic             AXI_arvalid,
  input  logic             AXI_arready,
  input  logic             AXI_rvalid,
  input  logic             AXI_rlast,
  output logic             AXI_rready,
  output logic [N-1:0]     wr_en,
  output logic [4:0]       wr_addr,
  output logic [IDW-1:0]   grant_id,
  output logic             busy,
  output logic             err
);
  localparam logic [3:0] LAST = 4'(BEATS - 1);
  state_t state;
  logic [IDW-1:0] rr, gnt;
  logic any, acc;
  logic [3:0] beat;
  logic [31:0] sel_addr;
  rr_pick #(.N(N), .IDW(IDW)) u_pick (.req(req_valid), .ptr(rr), .gnt_idx(gnt), .any(any));
  always_comb begin
    sel_addr = '0;
    for (int i = 0; i < N; i++)
      if (gnt == IDW'(i)) sel_addr = req_addr[32*i +: 32];
  end
  assign acc = AXI_rvalid & AXI_rready;
  assign wr_en = acc ? N'(1) << grant_id : '0;
  assign wr_addr = {AXI_araddr[6], beat};
  assign AXI_arlen = LAST;
  assign busy = state != S_IDLE;
  always_ff @(posedge AXI_clk or negedge AXI_rst_n) begin
    if (!AXI_rst_n) begin
      state <= S_IDLE;
      AXI_arvalid <= 1'b0;
      AXI_rready <= 1'b0;
      AXI_araddr <= '0;
      req_ready <= '0;
      grant_id <= '0;
      rr <= IDW'(N - 1);
      beat <= '0;
      err <= 1'b0;
    end else begin
      req_ready <= '0;
      case (state)
        S_IDLE: if (any) begin
          grant_id <= gnt;
          AXI_araddr <= sel_addr & ~32'(LINE_BYTES - 1);
          req_ready <= N'(1) << gnt;
          AXI_arvalid <= 1'b1;
          state <= S_ADDR;
        end
        S_ADDR: if (AXI_arready) begin
          AXI_arvalid <= 1'b0;
          AXI_rready <= 1'b1;
          beat <= '0;
          state <= S_DATA;
        end
        S_DATA: if (acc) begin
          beat <= beat == LAST ? '0 : beat + 4'd1;
          if (AXI_rlast) begin
            AXI_rready <= 1'b0;
            rr <= grant_id;
            state <= S_IDLE;
            err <= err | (beat != LAST);
          end else if (beat == LAST) err <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb_axi_rd_arbiter: randomized bursts checked against a round-robin reference model
module tb_axi_rd_arbiter;
  localparam int N = 3;
  localparam int BEATS = 16;
  localparam int IDW = 3;
  logic clk = 0;
  logic rst_n = 0;
  logic [N-1:0] req_valid, req_ready, wr_en;
  logic [32*N-1:0] req_addr;
  logic [31:0] araddr;
  logic [3:0] arlen;
  logic arvalid, arready, rvalid, rlast, rready, busy, err;
  logic [4:0] wr_addr;
  logic [IDW-1:0] grant_id;
  int n_cmp = 0;
  int n_bad = 0;
  int rr_m;
  logic err_m;
  always #5 clk = ~clk;
  axi_rd_arbiter #(.N(N), .BEATS(BEATS), .IDW(IDW)) dut (
    .AXI_clk(clk), .AXI_rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready), .AXI_araddr(araddr), .AXI_arlen(arlen), .AXI_arvalid(arvalid),
    .AXI_arready(arready), .AXI_rvalid(rvalid), .AXI_rlast(rlast), .AXI_rready(rready),
    .wr_en(wr_en), .wr_addr(wr_addr), .grant_id(grant_id), .busy(busy), .err(err)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic int pick(input logic [N-1:0] rv);
    for (int i = 1; i <= N; i++) begin
      int j = (rr_m + i) % N;
      if (((rv >> j) & 1) != 0) return j;
    end
    return 0;
  endfunction
  task automatic burst(input logic [N-1:0] rv, input int ar_wait, input int gap_mode,
                       input int last_at, input int abort_at, input logic [31:0] a0);
    logic [31:0] a [N];
    logic [31:0] ea;
    logic v;
    int g, k, cyc;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      a[i] = $urandom;
      if (i == 0 && a0 != 0) a[i] = a0;
      req_addr[32*i +: 32] = a[i];
    end
    req_valid = rv;
    g = pick(rv);
    ea = {a[g][31:6], 6'b0};
    @(posedge clk); #1;
    chk("req_ready", req_ready, N'(1) << g);
    chk("arvalid", arvalid, 1);
    chk("araddr", araddr, ea);
    chk("grant_id", grant_id, g);
    chk("busy", busy, 1);
    repeat (ar_wait) begin
      @(negedge clk);
      req_valid = '0;
      arready = 0;
      @(posedge clk); #1;
      chk("arvalid_hold", arvalid, 1);
      chk("araddr_hold", araddr, ea);
      chk("req_ready_once", req_ready, 0);
    end
    @(negedge clk);
    req_valid = '0;
    arready = 1;
    @(posedge clk); #1;
    chk("ar_handshake", {arvalid, rready}, 2'b01);
    chk("req_ready_clr", req_ready, 0);
    k = 0;
    cyc = 0;
    while (k <= last_at) begin
      @(negedge clk);
      arready = 0;
      if (abort_at == k) begin
        rst_n = 0;
        #1;
        chk("rst_rready", rready, 0);
        chk("rst_arvalid", arvalid, 0);
        chk("rst_busy", busy, 0);
        rr_m = N - 1;
        err_m = 0;
        return;
      end
      v = (gap_mode == 0 || cyc > 60) ? 1'b1 : gap_mode == 1 ? (cyc % 3 == 0) : ($urandom_range(0, 2) != 0);
      cyc++;
      rvalid = v;
      rlast = v && k == last_at;
      #1;
      chk("wr_en", wr_en, v ? N'(1) << g : N'(0));
      if (v) begin
        chk("wr_addr", wr_addr, {ea[6], 4'(k % BEATS)});
        k++;
      end
    end
    if (last_at != BEATS - 1) err_m = 1;
    rr_m = g;
    @(posedge clk); #1;
    chk("rready_end", rready, 0);
    chk("busy_end", busy, 0);
    chk("err", err, err_m);
    @(negedge clk);
    rvalid = 0;
    rlast = 0;
  endtask
  initial begin
    req_valid = '0;
    req_addr = '0;
    arready = 0;
    rvalid = 0;
    rlast = 0;
    rr_m = N - 1;
    err_m = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_arvalid", arvalid, 0);
    chk("rst_rready", rready, 0);
    chk("rst_araddr", araddr, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("arlen", arlen, BEATS - 1);
    @(negedge clk);
    rst_n = 1;
    burst(3'b001, 0, 0, 15, -1, 32'h1000_0047);
    repeat (4) burst(3'b011, 0, 0, 15, -1, 0);
    burst(3'b100, 5, 0, 15, -1, 0);
    burst(3'b111, 0, 1, 15, -1, 0);
    repeat (25) burst(N'($urandom_range(1, (1 << N) - 1)), $urandom_range(0, 3), $urandom_range(0, 2), 15, -1, 0);
    burst(N'($urandom_range(1, (1 << N) - 1)), 0, 0, 7, -1, 0);
    burst(3'b011, 1, 2, 15, -1, 0);
    burst(3'b001, 0, 0, 18, -1, 0);
    burst(3'b110, 0, 0, 15, 5, 0);
    rvalid = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("post_rst_wr_en", wr_en, 0);
      chk("post_rst_rready", rready, 0);
    end
    @(negedge clk);
    rvalid = 0;
    chk("post_rst_err", err, 0);
    burst(3'b011, 0, 0, 15, -1, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/axi_rd_arbiter.md
Name: axi_rd_arbiter

Overview:
- Shares one AXI read channel (AR + R) between N stream-buffer fill requesters, e.g. several A2S-style readers each fetching 64-byte lines from a DDR ring buffer.
- Each requester hands over a line address. The block grants requesters round-robin, issues one fixed-length INCR burst at a time, and steers the returned R beats to the granted requester's buffer write port.
- Sits between the per-channel controllers and the AXI HP read port, in the AXI clock domain.

Parameters:
- N, 2, number of requesters (2..8).
- BEATS, 16, beats per burst; AXI_arlen is driven as BEATS-1.
- IDW, 3, width of grant_id (at least clog2(N)).

Ports:
- AXI_clk  in  1  AXI clock; the block's only clock.
- AXI_rst_n  in  1  reset, asynchronous assert, active-low.
- req_valid  in  N  requester i has a line address pending.
- req_addr  in  32*N  line byte address; slice i is [32*i+31:32*i].
- req_ready  out  N  one-cycle pulse: request i accepted.
- AXI_araddr  out  32  burst address, with [5:0] forced to 0.
- AXI_arlen  out  4  constant BEATS-1.
- AXI_arvalid  out  1  AR valid.
- AXI_arready  in  1  AR ready.
- AXI_rvalid  in  1  R valid.
- AXI_rlast  in  1  R last.
- AXI_rready  out  1  R ready.
- wr_en  out  N  buffer write strobe, one-hot on the granted requester.
- wr_addr  out  5  buffer word address: {araddr[6], beat[3:0]}.
- grant_id  out  IDW  index of the current or last granted requester.
- busy  out  1  high in ADDR or DATA state.
- err  out  1  sticky flag: rlast mismatch.

Behaviour:
- Reset (async, AXI_rst_n=0):
  - state=IDLE.
  - AXI_arvalid=0, AXI_rready=0, AXI_araddr=0.
  - req_ready=0, wr_en=0, wr_addr=0.
  - grant_id=0, rr pointer=N-1, so requester 0 wins first. err=0.
- Reset mid-burst:
  - All state is dropped at once; no completion signalling.
  - Outstanding R beats after release are ignored (rready=0).
- IDLE:
  - If any req_valid, pick the first asserted index searching from rr+1 modulo N.
  - Registered on the same edge: grant_id, AXI_araddr={req_addr[g][31:6],6'b0}, req_ready[g]=1 for exactly one cycle, AXI_arvalid=1, state=ADDR.
  - Latency from req_valid to AXI_arvalid is 1 cycle.
  - With no req_valid, stay in IDLE.
- ADDR:
  - Hold AXI_arvalid and AXI_araddr stable until AXI_arready.
  - On the edge where AXI_arvalid & AXI_arready: AXI_arvalid=0, AXI_rready=1, beat=0, state=DATA.
- DATA:
  - Beat accepted when AXI_rvalid & AXI_rready.
  - wr_en[g] is combinational on that accepted beat; all other wr_en bits are 0.
  - wr_addr={AXI_araddr[6],beat} is valid in the same cycle.
  - beat increments after each accepted beat and wraps at BEATS-1.
  - On an accepted beat with AXI_rlast=1: AXI_rready=0 on the next edge, rr=grant_id, state=IDLE.
- Throughput:
  - At least one IDLE cycle between bursts.
  - One burst outstanding at a time; no AR pipelining.
- rlast mismatch:
  - If rlast arrives while beat!=BEATS-1, set err and end the burst as normal.
  - If beat=BEATS-1 is accepted without rlast, set err. Stay in DATA, keep writing with beat wrapped to 0, and wait for rlast.
  - err clears only on reset.
- req_valid dropped:
  - A requester may drop req_valid before req_ready; it is then simply not granted.
  - After req_ready, the requester's req_addr may change freely.
- Simultaneous requests: round-robin only; no starvation; worst-case wait is N-1 bursts.
- Outputs are undefined for indices at or above N; grant_id never exceeds N-1.

Decomposition:
- Shared package (a2s_pkg / config.v defines):
  - state encodings S_IDLE=2'd0, S_ADDR=2'd1, S_DATA=2'd2.
  - LINE_BYTES=64, BEATS_DEF=16.
- One sub-module: rr_pick. Combinational round-robin priority encoder with inputs req[N] and ptr[IDW], outputs gnt_idx[IDW] and any. It is reused by later write-side arbiters.

Test Plan:
- Single request:
  - Stimulus: req_valid=01, req_addr0=0x1000_0047; arready high; 16 R beats back-to-back, rlast on the 16th.
  - Expect: req_ready[0] pulses once; araddr=0x1000_0040; wr_addr 0x10..0x1F with wr_en[0] only.
  - Expect: rready low 1 cycle after rlast; busy=0; err=0.
- Simultaneous requests from reset:
  - Stimulus: req_valid=11 held.
  - Expect: grants alternate 0,1,0,1 over 4 bursts; grant_id sequence matches; no wr_en[1] during requester 0's bursts.
- AR backpressure:
  - Stimulus: AXI_arready held low 5 cycles.
  - Expect: arvalid and araddr stable all 5 cycles; exactly one AR handshake.
- R gaps:
  - Stimulus: rvalid toggles 1,0,0,1 pattern.
  - Expect: exactly 16 wr_en pulses; wr_addr[3:0] contiguous 0..15.
- rlast mismatch:
  - Early rlast on beat 7 → err=1, state=IDLE, next request served normally.
  - Missing rlast on beat 15 → err=1, block waits for rlast.
- Reset mid-burst:
  - Stimulus: assert AXI_rst_n=0 on beat 5.
  - Expect: rready=0 and arvalid=0 immediately (asynchronous); after release, grant restarts at requester 0.
